// File: rtl/operand_sel_stage_pkg.sv
// Shared definitions for the operand-select pipeline stage.
// Latency: n/a (types, constants and helper function only).
// Backpressure: n/a.
package operand_sel_stage_pkg;

   // Default datapath width for operand-select instances.
   localparam int DEF_WIDTH = 32;

   // Legacy 3-source select encodings used by the EX-stage forwarding path.
   localparam logic [1:0] SRC_REG = 2'd0;
   localparam logic [1:0] SRC_MEM = 2'd1;
   localparam logic [1:0] SRC_WB  = 2'd2;

   // Select width for n sources. A 2-input mux still needs a 1-bit select,
   // so the width never drops below 1.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/operand_sel_mux.sv
// Combinational N:1 operand mux with an illegal-select flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the result with its own handshake.
//
// Ports:
//   in_data  flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel      binary source index
//   value    selected source, or 0 when sel is out of range
//   err      1 when sel >= NUM_IN
module operand_sel_mux
   import operand_sel_stage_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int NUM_IN = 3,
   localparam int SEL_W  = sel_w(NUM_IN)
)(
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        value,
   output logic                    err
);

   // Matching against every legal index keeps the out-of-range case implicit:
   // if no index matches, the defaults (value 0, err 1) remain. For
   // power-of-two NUM_IN every encoding matches, so err is constant 0.
   always_comb begin
      value = '0;
      err   = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            value = in_data[k*WIDTH +: WIDTH];
            err   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/operand_sel_stage.sv
// Registered operand-select stage with a 2-entry (output + skid) buffer.
// Latency: 1 cycle from acceptance to out_data when the output register is free.
// Backpressure: in_ready is purely registered (drops only when the skid entry is full); full throughput under stalls.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/in_sel        flattened sources and source index
//   in_valid/in_ready     upstream handshake
//   flush                 discard held and incoming beats (synchronous)
//   out_data/out_sel_err  selected beat and its illegal-select flag
//   out_valid/out_ready   downstream handshake
//   err_count             saturating count of accepted illegal selects
module operand_sel_stage
   import operand_sel_stage_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int NUM_IN = 3,
   parameter  int CNT_W  = 16,
   localparam int SEL_W  = sel_w(NUM_IN)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        err_count
);

   logic [WIDTH-1:0] mux_data;
   logic             mux_err;

   operand_sel_mux #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_mux (
      .in_data (in_data),
      .sel     (in_sel),
      .value   (mux_data),
      .err     (mux_err)
   );

   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic             skid_valid;
   logic             in_xfer;
   logic             out_free;
   logic             cnt_sat;

   // in_ready depends only on state, so out_ready never reaches upstream
   // combinationally; the skid entry absorbs the one beat in flight.
   assign in_ready = rst_n & ~skid_valid;
   assign in_xfer  = in_valid & in_ready & ~flush;
   assign out_free = ~out_valid | out_ready;
   assign cnt_sat  = &err_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data    <= '0;
         out_sel_err <= 1'b0;
         out_valid   <= 1'b0;
         skid_data   <= '0;
         skid_err    <= 1'b0;
         skid_valid  <= 1'b0;
         err_count   <= '0;
      end else begin
         if (flush) begin
            // Payload registers keep their last values; only valids drop.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
         end else if (out_free) begin
            if (skid_valid) begin
               // Older beat first; in_ready was 0 so nothing new arrives.
               out_data    <= skid_data;
               out_sel_err <= skid_err;
               out_valid   <= 1'b1;
               skid_valid  <= 1'b0;
            end else if (in_xfer) begin
               out_data    <= mux_data;
               out_sel_err <= mux_err;
               out_valid   <= 1'b1;
            end else begin
               out_valid   <= 1'b0;
            end
         end else if (in_xfer) begin
            // Output stalled: park the beat, which closes in_ready next cycle.
            skid_data  <= mux_data;
            skid_err   <= mux_err;
            skid_valid <= 1'b1;
         end

         // in_xfer already excludes flushed beats, so they are never counted.
         if (in_xfer && mux_err && !cnt_sat) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_operand_sel_stage.sv
module tb_operand_sel_stage;
   import operand_sel_stage_pkg::*;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: NUM_IN=3, WIDTH=32, CNT_W=4
   logic [95:0] in_data_a;
   logic [1:0]  in_sel_a;
   logic        in_valid_a, in_ready_a, flush_a;
   logic [31:0] out_data_a;
   logic        out_sel_err_a, out_valid_a, out_ready_a;
   logic [3:0]  err_count_a;

   // DUT B: NUM_IN=8, WIDTH=64, CNT_W=16
   logic [511:0] in_data_b;
   logic [2:0]   in_sel_b;
   logic         in_valid_b, in_ready_b, flush_b;
   logic [63:0]  out_data_b;
   logic         out_sel_err_b, out_valid_b, out_ready_b;
   logic [15:0]  err_count_b;

   operand_sel_stage #(.WIDTH(32), .NUM_IN(3), .CNT_W(4)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data_a),
      .in_sel      (in_sel_a),
      .in_valid    (in_valid_a),
      .in_ready    (in_ready_a),
      .flush       (flush_a),
      .out_data    (out_data_a),
      .out_sel_err (out_sel_err_a),
      .out_valid   (out_valid_a),
      .out_ready   (out_ready_a),
      .err_count   (err_count_a)
   );

   operand_sel_stage #(.WIDTH(64), .NUM_IN(8), .CNT_W(16)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data_b),
      .in_sel      (in_sel_b),
      .in_valid    (in_valid_b),
      .in_ready    (in_ready_b),
      .flush       (flush_b),
      .out_data    (out_data_b),
      .out_sel_err (out_sel_err_b),
      .out_valid   (out_valid_b),
      .out_ready   (out_ready_b),
      .err_count   (err_count_b)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t qa[$];
   exp_t qb[$];
   int   cnt_a    = 0;
   int   nb_out   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample just before the rising edge: retire output transfers against the
   // scoreboard, apply flush, then record accepted input beats. Ends on the
   // following falling edge with the post-edge outputs settled.
   task automatic step();
      exp_t e;
      #3;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         cnt_a = 0;
      end else begin
         if (out_valid_a && out_ready_a) begin
            check("a_beat_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
               e = qa.pop_front();
               check("a_sb_data", out_data_a, e.data);
               check("a_sb_err", out_sel_err_a, e.err);
            end
         end
         if (flush_a) qa.delete();
         if (in_valid_a && in_ready_a && !flush_a) begin
            if (in_sel_a < 2'd3) begin
               e.data = 64'(in_data_a[in_sel_a*32 +: 32]);
               e.err  = 1'b0;
            end else begin
               e.data = 64'd0;
               e.err  = 1'b1;
               if (cnt_a < 15) cnt_a++;
            end
            qa.push_back(e);
         end

         if (out_valid_b && out_ready_b) begin
            nb_out++;
            check("b_beat_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
               e = qb.pop_front();
               check("b_sb_data", out_data_b, e.data);
               check("b_sb_err", out_sel_err_b, e.err);
            end
         end
         if (flush_b) qb.delete();
         if (in_valid_b && in_ready_b && !flush_b) begin
            e.data = in_data_b[in_sel_b*64 +: 64];
            e.err  = 1'b0;
            qb.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      in_data_a = {32'h33, 32'h22, 32'h11};
      in_sel_a = SRC_REG; in_valid_a = 1'b1; flush_a = 1'b0; out_ready_a = 1'b1;
      in_data_b = '0; in_sel_b = '0; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
      @(negedge clk);

      // Reset with in_valid asserted.
      step();
      step();
      check("rst_out_data", out_data_a, 0);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_sel_err", out_sel_err_a, 0);
      check("rst_in_ready", in_ready_a, 0);
      check("rst_err_count", err_count_a, 0);
      check("rst_b_out_valid", out_valid_b, 0);
      rst_n = 1'b1;
      in_valid_a = 1'b0;
      #1;
      check("rel_in_ready", in_ready_a, 1);
      step();

      // Streaming.
      in_valid_a = 1'b1;
      in_sel_a = SRC_REG; step();
      check("str_data0", out_data_a, 32'h11);
      check("str_valid0", out_valid_a, 1);
      in_sel_a = SRC_MEM; step();
      check("str_data1", out_data_a, 32'h22);
      check("str_valid1", out_valid_a, 1);
      in_sel_a = SRC_WB; step();
      check("str_data2", out_data_a, 32'h33);
      check("str_valid2", out_valid_a, 1);
      check("str_sel_err", out_sel_err_a, 0);
      in_valid_a = 1'b0; step();
      check("str_idle", out_valid_a, 0);

      // Back-pressure: A into OUT, B into SKID.
      out_ready_a = 1'b0;
      in_valid_a = 1'b1;
      in_sel_a = SRC_REG; step();
      in_sel_a = SRC_MEM; step();
      check("bp_hold_a", out_data_a, 32'h11);
      check("bp_in_ready", in_ready_a, 0);
      in_sel_a = SRC_WB; step();
      check("bp_stable_data", out_data_a, 32'h11);
      check("bp_stable_valid", out_valid_a, 1);
      in_valid_a = 1'b0; out_ready_a = 1'b1; step();
      check("bp_deliver_b", out_data_a, 32'h22);
      check("bp_in_ready_back", in_ready_a, 1);
      step();
      check("bp_empty", out_valid_a, 0);

      // Illegal select, then saturation of the 4-bit counter.
      in_data_a = {32'hDEAD, 32'hBEEF, 32'hCAFE};
      in_valid_a = 1'b1; in_sel_a = 2'd3; step();
      check("ill_data", out_data_a, 0);
      check("ill_sel_err", out_sel_err_a, 1);
      check("ill_count1", err_count_a, 1);
      for (int i = 0; i < 20; i++) step();
      in_valid_a = 1'b0; step(); step();
      check("ill_count_sat", err_count_a, 4'hF);
      check("ill_count_model", err_count_a, cnt_a);

      // Fresh reset, then flush while OUT and SKID are full.
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      in_data_a = {32'h33, 32'h22, 32'h11};
      out_ready_a = 1'b0; in_valid_a = 1'b1;
      in_sel_a = SRC_REG; step();
      in_sel_a = 2'd3; step();
      check("fl_pre_in_ready", in_ready_a, 0);
      check("fl_pre_count", err_count_a, 1);
      flush_a = 1'b1; step();
      check("fl_out_valid", out_valid_a, 0);
      check("fl_in_ready", in_ready_a, 1);
      check("fl_count", err_count_a, 1);
      check("fl_keep_data", out_data_a, 32'h11);
      step();
      check("fl_count_incoming", err_count_a, 1);
      check("fl_out_valid2", out_valid_a, 0);
      flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
      step(); step(); step();
      check("fl_no_delivery", out_valid_a, 0);
      check("fl_count_model", err_count_a, cnt_a);

      // Wide config with randomized valid/ready.
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 16; i++) in_data_b[i*32 +: 32] = $urandom();
         in_sel_b    = 3'($urandom_range(0, 7));
         in_valid_b  = ($urandom_range(0, 3) != 0);
         out_ready_b = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid_b = 1'b0; out_ready_b = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("b_drained", qb.size(), 0);
      check("b_out_idle", out_valid_b, 0);
      check("b_err_count", err_count_b, 0);
      check("b_traffic", nb_out > 1000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_sel_stage.md
Name: operand_sel_stage

Overview:
- Parametrised N-input operand-select stage for the pipelined datapath (EX-stage forwarding / writeback select).
- Selects one of NUM_IN WIDTH-bit sources by a binary select and registers the result.
- Provides a valid/ready handshake with a 2-entry skid buffer, so it gives full throughput under back-pressure.
- Supports a synchronous flush and flags and counts illegal selects.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_IN, 3, number of sources, 2..16.
- SEL_W, $clog2(NUM_IN) (minimum 1), select width; derived, must not be overridden.
- CNT_W, 16, width of the saturating illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  source index.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat.
- flush  in  1  discard all held and incoming beats.
- out_data  out  WIDTH  selected, registered data.
- out_sel_err  out  1  the beat on out_data had an illegal select.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- err_count  out  CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_data=0, out_sel_err=0, out_valid=0, err_count=0; the skid entry is cleared.
  - in_ready=0 while rst_n=0; no transfer occurs in a reset cycle.
- Selection (combinational, before registering):
  - sel < NUM_IN: value = source[sel], err=0.
  - sel >= NUM_IN (reachable only when NUM_IN is not a power of 2): value = 0, err=1.
- Transfers:
  - Input transfer: in_valid & in_ready & ~flush at a clk edge.
  - Output transfer: out_valid & out_ready.
- in_ready = rst_n & ~skid_valid. It is registered-state only, with no combinational path from out_ready.
- Storage: output register (OUT) and skid register (SKID). Each holds {data, err} plus a valid bit.
- Per edge, when not in reset and flush=0:
  - OUT empty, or OUT drained this edge:
    - SKID valid: SKID moves to OUT. A simultaneous input transfer is impossible because in_ready=0.
    - Otherwise, on an input transfer, the new beat loads OUT.
    - Otherwise OUT becomes empty.
  - OUT full and stalled: an input transfer loads SKID, so in_ready drops the next cycle.
- Latency: an accepted beat appears on out_data 1 cycle after acceptance when OUT is free. Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering is strictly FIFO; a beat is never duplicated or dropped except by flush.
- Flush (synchronous):
  - out_valid=0 and skid valid=0 next cycle; any same-cycle input beat is discarded and not counted.
  - out_data and out_sel_err keep their last values.
  - in_ready=1 the cycle after.
- err_count:
  - Increments by 1 on each input transfer with err=1.
  - Saturates at all-ones and never wraps.
  - Not cleared by flush; cleared only by reset.
- out_data, out_sel_err and out_valid must stay stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared pipeline package holds:
  - SEL_W derivation function (clog2 with a minimum of 1).
  - Default WIDTH (32).
  - Legacy 3-source select encodings: SRC_REG=0, SRC_MEM=1, SRC_WB=2.
- One combinational sub-module, operand_sel_mux:
  - Parametrised by WIDTH and NUM_IN.
  - Outputs the selected value and the err bit.
  - operand_sel_stage instantiates it once and adds the handshake/skid logic.

Test Plan:
- Reset then idle, NUM_IN=3, WIDTH=32: hold rst_n=0 for 2 cycles with in_valid=1 -> all outputs 0, in_ready=0, err_count=0. After release, in_ready=1.
- Streaming: sources {0x11,0x22,0x33}, sel 0,1,2 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 on cycles t+1..t+3, out_valid continuous, out_sel_err=0.
- Back-pressure: out_ready=0 while beats A and B are accepted -> A held on out_data, B in SKID, in_ready=0. Raise out_ready -> A then B delivered in order on consecutive cycles, then in_ready=1.
- Illegal select: NUM_IN=3, sel=3, source data nonzero -> out_data=0, out_sel_err=1, err_count=1. Repeat 2^CNT_W+5 times (CNT_W=4) -> err_count saturates at 0xF.
- Flush mid-stall: OUT and SKID full, flush=1 with in_valid=1 and sel=3 -> next cycle out_valid=0, in_ready=1, err_count unchanged, the flushed beats are never delivered.
- Wide config: NUM_IN=8, WIDTH=64, randomized valid/ready against a scoreboard for 10k cycles -> no loss, no duplication, order preserved, no illegal-select errors.
